// File: rtl/rubiks_pkg.sv
// Shared definitions for the cube robot: move codes, sticker colours,
// scheduler state encoding and small decode helpers.
package rubiks_pkg;

    localparam int MOVE_W = 5;

    // Face turns in ULFRBD order, each as X, X', X2; 31 is a no-op.
    typedef enum logic [MOVE_W-1:0] {
        MV_U  = 5'd0,  MV_U_PRIME = 5'd1,  MV_U2 = 5'd2,
        MV_L  = 5'd3,  MV_L_PRIME = 5'd4,  MV_L2 = 5'd5,
        MV_F  = 5'd6,  MV_F_PRIME = 5'd7,  MV_F2 = 5'd8,
        MV_R  = 5'd9,  MV_R_PRIME = 5'd10, MV_R2 = 5'd11,
        MV_B  = 5'd12, MV_B_PRIME = 5'd13, MV_B2 = 5'd14,
        MV_D  = 5'd15, MV_D_PRIME = 5'd16, MV_D2 = 5'd17,
        MV_NOP = 5'd31
    } move_e;

    typedef enum logic [2:0] {
        COL_WHITE  = 3'd0,
        COL_YELLOW = 3'd1,
        COL_RED    = 3'd2,
        COL_ORANGE = 3'd3,
        COL_GREEN  = 3'd4,
        COL_BLUE   = 3'd5
    } color_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_HALT      = 3'd4
    } state_e;

    localparam int FAULT_OVERRUN  = 0;
    localparam int FAULT_BAD_CODE = 1;
    localparam int FAULT_TIMEOUT  = 2;

    localparam logic [7:0] MOVE_COUNT_MAX = 8'd255;

    function automatic logic is_turn(input logic [MOVE_W-1:0] code);
        return code <= MV_D2;
    endfunction

    function automatic logic is_nop(input logic [MOVE_W-1:0] code);
        return code == MV_NOP;
    endfunction

    // A counter holding CYCLES-1 needs $clog2(CYCLES) bits; keep at least one.
    function automatic int timer_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Non-wrapping down-counter: load arms it for CYCLES enabled cycles, and
// expired is high during the last of them.
module cycle_timer
    import rubiks_pkg::*;
#(
    parameter int CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int WIDTH = timer_width(CYCLES);
    localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates scan and solver move requests, drives the motor one move at a
// time, waits for completion and sensor settling, and keeps fault flags.
module move_scheduler
    import rubiks_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2500000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_req,
    input  logic [4:0] scan_move,
    input  logic       solve_valid,
    input  logic [4:0] solve_move,
    output logic       solve_ready,
    output logic [4:0] motor_move,
    output logic       motor_start,
    input  logic       motor_done,
    output logic       color_sensor_stable,
    output logic       busy,
    output logic [7:0] move_count,
    output logic [2:0] fault
);

    // Solver handshake: a move transfers on a rising edge where solve_valid and
    // solve_ready are both high; solve_valid/solve_move must hold until then.

    state_e     state_q, state_d;
    logic       pend_valid_q, pend_valid_d;
    logic [4:0] pend_move_q, pend_move_d;
    logic [4:0] move_q, move_d;
    logic       req_scan_q, req_scan_d;
    logic       stable_q, stable_d;
    logic [7:0] count_q, count_d;
    logic [2:0] fault_q, fault_d;

    logic       in_idle;
    logic       take_pend;
    logic       take_solve;
    logic       accept;
    logic [4:0] acc_move;
    logic       acc_turn;
    logic       acc_nop;
    logic       acc_bad;

    logic       settle_load, settle_en, settle_expired;
    logic       timeout_load, timeout_en, timeout_expired;

    assign in_idle    = (state_q == ST_IDLE);
    assign take_pend  = in_idle && pend_valid_q;
    assign take_solve = in_idle && !pend_valid_q && !scan_req && solve_valid;
    assign accept     = take_pend || take_solve;
    assign acc_move   = take_pend ? pend_move_q : solve_move;
    assign acc_turn   = is_turn(acc_move);
    assign acc_nop    = is_nop(acc_move);
    assign acc_bad    = !acc_turn && !acc_nop;

    // Both timers are armed on the edge that enters their state.
    assign settle_load  = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
    assign settle_en    = (state_q == ST_SETTLE);
    assign timeout_load = (state_q == ST_ISSUE);
    assign timeout_en   = (state_q == ST_WAIT_DONE);

    cycle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (settle_load),
        .enable  (settle_en),
        .expired (settle_expired)
    );

    cycle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (timeout_load),
        .enable  (timeout_en),
        .expired (timeout_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_turn) begin
                        state_d = ST_ISSUE;
                    end else if (acc_nop) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ISSUE:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (motor_done) begin
                    state_d = ST_SETTLE;
                end else if (timeout_expired) begin
                    state_d = ST_HALT;
                end
            end
            ST_SETTLE: begin
                if (settle_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // solve_ready is gated by reset so every output reads 0 while held in reset.
    always_comb begin
        motor_start = 1'b0;
        motor_move  = '0;
        solve_ready = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy        = 1'b0;
                solve_ready = reset && !pend_valid_q && !scan_req;
            end
            ST_ISSUE: begin
                motor_start = 1'b1;
                motor_move  = move_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_move_d  = pend_move_q;
        move_d       = move_q;
        req_scan_d   = req_scan_q;
        stable_d     = stable_q;
        count_d      = count_q;
        fault_d      = fault_q;

        if (take_pend) begin
            pend_valid_d = 1'b0;
        end
        // A slot freed this cycle can take a new request straight away.
        if (scan_req && (state_q != ST_HALT)) begin
            if (pend_valid_q && !take_pend) begin
                fault_d[FAULT_OVERRUN] = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_move_d  = scan_move;
            end
        end

        if (accept) begin
            move_d     = acc_move;
            req_scan_d = take_pend;
            // A rejected scan code still releases the scanner.
            stable_d   = take_pend && acc_bad;
            if (acc_bad) begin
                fault_d[FAULT_BAD_CODE] = 1'b1;
            end
        end

        if (state_q == ST_WAIT_DONE) begin
            if (motor_done) begin
                if (count_q != MOVE_COUNT_MAX) begin
                    count_d = count_q + 8'd1;
                end
            end else if (timeout_expired) begin
                fault_d[FAULT_TIMEOUT] = 1'b1;
            end
        end

        if ((state_q == ST_SETTLE) && settle_expired && req_scan_q) begin
            stable_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_move_q  <= '0;
            move_q       <= '0;
            req_scan_q   <= 1'b0;
            stable_q     <= 1'b0;
            count_q      <= '0;
            fault_q      <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_move_q  <= pend_move_d;
            move_q       <= move_d;
            req_scan_q   <= req_scan_d;
            stable_q     <= stable_d;
            count_q      <= count_d;
            fault_q      <= fault_d;
        end
    end

    assign color_sensor_stable = stable_q;
    assign move_count          = count_q;
    assign fault               = fault_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with SETTLE_CYCLES=4, TIMEOUT_CYCLES=16.
// Expected motor moves are queued ahead of time and checked on each motor_start.
module tb_move_scheduler;

    logic       clock;
    logic       reset;
    logic       scan_req;
    logic [4:0] scan_move;
    logic       solve_valid;
    logic [4:0] solve_move;
    logic       solve_ready;
    logic [4:0] motor_move;
    logic       motor_start;
    logic       motor_done;
    logic       color_sensor_stable;
    logic       busy;
    logic [7:0] move_count;
    logic [2:0] fault;

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_m;

    move_scheduler #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .scan_req            (scan_req),
        .scan_move           (scan_move),
        .solve_valid         (solve_valid),
        .solve_move          (solve_move),
        .solve_ready         (solve_ready),
        .motor_move          (motor_move),
        .motor_start         (motor_start),
        .motor_done          (motor_done),
        .color_sensor_stable (color_sensor_stable),
        .busy                (busy),
        .move_count          (move_count),
        .fault               (fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every motor_start must match the oldest queued expected move.
    always @(negedge clock) begin
        if (motor_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_start", {27'd0, motor_move}, 32'h20);
            end else begin
                exp_m = exp_q.pop_front();
                check_eq("start_move", {27'd0, motor_move}, {27'd0, exp_m});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_motor_start"}, motor_start, 0);
        check_eq({pfx, "_motor_move"}, motor_move, 0);
        check_eq({pfx, "_solve_ready"}, solve_ready, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_stable"}, color_sensor_stable, 0);
        check_eq({pfx, "_move_count"}, move_count, 0);
        check_eq({pfx, "_fault"}, fault, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && (n < budget)) begin
            tick();
            #1;
            n++;
        end
        check_eq("idle_reached", busy, 0);
    endtask

    task automatic apply_reset(input string pfx);
        tick();
        reset = 1'b0;
        scan_req = 1'b0;
        solve_valid = 1'b0;
        motor_done = 1'b0;
        tick();
        #1;
        check_all_zero(pfx);
        reset = 1'b1;
    endtask

    // Called mid-cycle while idle and ready; runs one solver move to completion.
    task automatic do_solve_move(input logic [4:0] code);
        solve_valid = 1'b1;
        solve_move  = code;
        exp_q.push_back(code);
        tick();
        solve_valid = 1'b0;
        #1;
        tick();
        motor_done = 1'b1;
        #1;
        tick();
        motor_done = 1'b0;
        #1;
        wait_idle(8);
    endtask

    initial begin
        reset = 1'b0;
        scan_req = 1'b0;
        scan_move = '0;
        solve_valid = 1'b0;
        solve_move = '0;
        motor_done = 1'b0;
        tick();
        tick();
        #1;
        check_all_zero("rst");
        reset = 1'b1;
        #1;
        check_eq("rst_release_ready", solve_ready, 1);

        // Scan move 5: start two cycles after the request, stable after settle.
        tick(); scan_req = 1'b1; scan_move = 5'd5; exp_q.push_back(5'd5); #1;
        check_eq("t1_ready_blocked", solve_ready, 0);
        tick(); scan_req = 1'b0; #1;
        check_eq("t1_no_early_start", motor_start, 0);
        tick(); #1;
        check_eq("t1_start", motor_start, 1);
        check_eq("t1_move", motor_move, 5);
        tick(); motor_done = 1'b1; #1;
        check_eq("t1_start_one_cycle", motor_start, 0);
        tick(); motor_done = 1'b0; #1;
        check_eq("t1_count", move_count, 1);
        check_eq("t1_stable_settle0", color_sensor_stable, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("t1_stable_settle", color_sensor_stable, 0);
            check_eq("t1_busy_settle", busy, 1);
        end
        tick(); #1;
        check_eq("t1_stable", color_sensor_stable, 1);
        check_eq("t1_idle", busy, 0);

        // Scan and solver together: scan first, solver waits for IDLE.
        tick(); scan_req = 1'b1; scan_move = 5'd0; solve_valid = 1'b1; solve_move = 5'd9;
        exp_q.push_back(5'd0); #1;
        check_eq("t2_ready_c0", solve_ready, 0);
        tick(); scan_req = 1'b0; #1;
        check_eq("t2_ready_c1", solve_ready, 0);
        tick(); #1;
        check_eq("t2_ready_issue", solve_ready, 0);
        check_eq("t2_scan_first", motor_move, 0);
        tick(); motor_done = 1'b1; #1;
        tick(); motor_done = 1'b0; #1;
        check_eq("t2_ready_settle0", solve_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("t2_ready_settle", solve_ready, 0);
        end
        tick(); #1;
        check_eq("t2_ready_idle", solve_ready, 1);
        check_eq("t2_stable_scan", color_sensor_stable, 1);
        exp_q.push_back(5'd9);
        tick(); solve_valid = 1'b0; #1;
        check_eq("t2_stable_cleared", color_sensor_stable, 0);
        check_eq("t2_solve_start", motor_start, 1);
        check_eq("t2_solve_move", motor_move, 9);
        tick(); motor_done = 1'b1; #1;
        tick(); motor_done = 1'b0; #1;
        wait_idle(10);
        check_eq("t2_stable_solver", color_sensor_stable, 0);
        check_eq("t2_count", move_count, 3);

        // Two scan requests during WAIT_DONE: first served, second dropped.
        tick(); scan_req = 1'b1; scan_move = 5'd3; exp_q.push_back(5'd3); #1;
        tick(); scan_req = 1'b0; #1;
        tick(); #1;
        tick(); scan_req = 1'b1; scan_move = 5'd7; exp_q.push_back(5'd7); #1;
        tick(); scan_move = 5'd8; #1;
        check_eq("t3_fault_before", fault, 0);
        tick(); scan_req = 1'b0; #1;
        check_eq("t3_fault_overrun", fault, 3'b001);
        tick(); motor_done = 1'b1; #1;
        tick(); motor_done = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
        end
        tick(); #1;
        check_eq("t3_stable_first", color_sensor_stable, 1);
        tick(); #1;
        check_eq("t3_pending_start", motor_start, 1);
        check_eq("t3_pending_move", motor_move, 7);
        check_eq("t3_stable_cleared", color_sensor_stable, 0);
        tick(); motor_done = 1'b1; #1;
        tick(); motor_done = 1'b0; #1;
        wait_idle(10);
        check_eq("t3_fault_final", fault, 3'b001);
        check_eq("t3_count", move_count, 5);

        // Solver NOP: settle only, no motor activity, stable stays low.
        tick(); solve_valid = 1'b1; solve_move = 5'd31; #1;
        check_eq("t4_ready", solve_ready, 1);
        tick(); solve_valid = 1'b0; #1;
        check_eq("t4_busy", busy, 1);
        check_eq("t4_stable_cleared", color_sensor_stable, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("t4_busy_settle", busy, 1);
        end
        tick(); #1;
        check_eq("t4_idle", busy, 0);
        check_eq("t4_stable", color_sensor_stable, 0);
        check_eq("t4_count", move_count, 5);

        // Invalid scan code 20.
        apply_reset("t5_rst");
        tick(); scan_req = 1'b1; scan_move = 5'd20; #1;
        tick(); scan_req = 1'b0; #1;
        check_eq("t5_stable_before", color_sensor_stable, 0);
        tick(); #1;
        check_eq("t5_stable", color_sensor_stable, 1);
        check_eq("t5_fault", fault, 3'b010);
        check_eq("t5_idle", busy, 0);
        check_eq("t5_count", move_count, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
        end

        // Missing motor_done: timeout after 16 WAIT_DONE cycles, then HALT.
        apply_reset("t6_rst");
        tick(); solve_valid = 1'b1; solve_move = 5'd2; exp_q.push_back(5'd2); #1;
        tick(); solve_valid = 1'b0; #1;
        check_eq("t6_start", motor_start, 1);
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
        end
        tick(); #1;
        check_eq("t6_last_wait_fault", fault, 0);
        check_eq("t6_last_wait_busy", busy, 1);
        tick(); #1;
        check_eq("t6_fault_timeout", fault, 3'b100);
        check_eq("t6_halt_busy", busy, 1);
        tick(); scan_req = 1'b1; scan_move = 5'd1; solve_valid = 1'b1; solve_move = 5'd4; #1;
        check_eq("t6_halt_ready", solve_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("t6_halt_ready_hold", solve_ready, 0);
            check_eq("t6_halt_no_start", motor_start, 0);
        end
        tick(); scan_req = 1'b0; solve_valid = 1'b0; motor_done = 1'b1; #1;
        tick(); motor_done = 1'b0; #1;
        check_eq("t6_halt_count", move_count, 0);
        check_eq("t6_halt_stays", busy, 1);
        check_eq("t6_halt_fault", fault, 3'b100);
        tick(); reset = 1'b0; #1;
        tick(); #1;
        check_all_zero("t6_rst");
        reset = 1'b1;
        #1;
        check_eq("t6_ready_after_rst", solve_ready, 1);

        // Reset during WAIT_DONE; the late motor_done must be ignored.
        tick(); solve_valid = 1'b1; solve_move = 5'd6; exp_q.push_back(5'd6); #1;
        tick(); solve_valid = 1'b0; #1;
        check_eq("t7_start", motor_start, 1);
        tick(); reset = 1'b0; #1;
        tick(); reset = 1'b1; motor_done = 1'b1; #1;
        check_eq("t7_idle_after_rst", busy, 0);
        tick(); motor_done = 1'b0; #1;
        check_eq("t7_count", move_count, 0);
        check_eq("t7_fault", fault, 0);
        check_eq("t7_still_idle", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
        end

        // Move counter saturation.
        for (int i = 0; i < 255; i++) begin
            do_solve_move(5'(i % 18));
        end
        check_eq("t8_count_255", move_count, 255);
        do_solve_move(5'd11);
        check_eq("t8_count_sat", move_count, 255);

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
